// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage with a DEPTH-entry prefetch FIFO.
//
// This block owns the fetch PC and issues sequential requests on the
// instruction side of the cache. Each returned instruction is buffered
// with its PC+4, so a stalled decode stage does not block the icache.
// A redirect flushes the queue and reloads the PC.
//
// Parameters:
//   WORD_W  - instruction/address width (default 32)
//   DEPTH   - queue entries, power of 2, minimum 2 (default 4)
//   PC_INIT - fetch PC after reset (default 0)
//
// Ports:
//   CLK, nRST          clock, asynchronous active-low reset
//   imemaddr, imemREN  fetch address (the PC) and read request
//   ihit, imemload     icache hit and the instruction it returns
//   redirect,
//   redirect_pc        flush the queue and restart fetch at redirect_pc
//   deq                decode consumes the head entry
//   out_valid,
//   out_instr,
//   out_npc            head entry, read combinationally (zero when empty)
//   count              queue occupancy
//
// Optional feature (macro FETCH_HALT_EN): a pushed instruction whose
// opcode field is all ones (halt) stops fetching until a redirect or a
// reset. Entries already queued, the halt included, still drain.
module fetch_queue #(
    parameter int                WORD_W  = 32,
    parameter int                DEPTH   = 4,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic [WORD_W-1:0]          imemaddr,
    output logic                       imemREN,
    input  logic                       ihit,
    input  logic [WORD_W-1:0]          imemload,
    input  logic                       redirect,
    input  logic [WORD_W-1:0]          redirect_pc,
    input  logic                       deq,
    output logic                       out_valid,
    output logic [WORD_W-1:0]          out_instr,
    output logic [WORD_W-1:0]          out_npc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WORD_W-1:0] PC_STEP  = WORD_W'(4);

    logic [WORD_W-1:0] pc;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [WORD_W-1:0] npc_mem   [DEPTH];
    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic              full;
    logic              push;
    logic              pop;

    // Full comes from the registered count only, so a pop while full
    // re-enables fetch on the following cycle, not combinationally.
    assign full = (count == CNT_FULL);

`ifdef FETCH_HALT_EN
    logic halted;
    logic is_halt;

    assign is_halt = (imemload[WORD_W-1 -: 6] == 6'b111111);
    assign imemREN = !full && !halted;
`else
    assign imemREN = !full;
`endif

    assign imemaddr = pc;

    // Redirect wins over everything: a same-cycle hit or dequeue is dropped.
    assign push = ihit && imemREN && !redirect;
    assign pop  = deq && out_valid && !redirect;

    // Show-ahead head; an empty queue presents a nop to decode.
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_npc   = out_valid ? npc_mem[rd_ptr]   : '0;

    // PC, pointers and occupancy. The PC only moves on a push or a
    // redirect, which keeps the request stable while waiting for a hit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc     <= PC_INIT;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef FETCH_HALT_EN
            halted <= 1'b0;
`endif
        end else if (redirect) begin
            pc     <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef FETCH_HALT_EN
            halted <= 1'b0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                pc     <= pc + PC_STEP;
`ifdef FETCH_HALT_EN
                if (is_halt) begin
                    halted <= 1'b1;
                end
`endif
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Entry storage. A flush leaves the contents alone because validity
    // is derived from count; only reset clears them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                npc_mem[i]   <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            npc_mem[wr_ptr]   <= pc + PC_STEP;
            instr_mem[wr_ptr] <= imemload;
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch stage that generalises the single IF/ID latch into a DEPTH-entry prefetch FIFO.
- Owns the fetch PC and issues sequential requests on the datapath_cache_if instruction side.
- Buffers {npc, instr} pairs so that decode stalls do not block the icache.
- Supports redirect (branch, jump or jr resolution) with a full queue flush.

Parameters:
PC_INIT, 0, reset value of fetch PC
DEPTH, 4, queue entries; power of 2, minimum 2
WORD_W, 32, instruction/address width

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
imemaddr  out  WORD_W  fetch address (= PC)
imemREN  out  1  instruction read request
ihit  in  1  icache hit; imemload valid this cycle
imemload  in  WORD_W  fetched instruction
redirect  in  1  flush queue and reload PC
redirect_pc  in  WORD_W  new fetch PC
deq  in  1  decode consumes head entry
out_valid  out  1  head entry valid
out_instr  out  WORD_W  head instruction (0 when !out_valid)
out_npc  out  WORD_W  head PC+4 (0 when !out_valid)
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: PC=PC_INIT, wr_ptr=rd_ptr=0, count=0, out_valid=0, out_instr=0, out_npc=0. imemREN=1 from the first cycle after reset.
- Request generation: imemREN = !full & !halted (halted exists only with the optional feature). imemaddr = PC.
- Request stability: PC does not change while imemREN=1 and ihit=0, so address and request stay stable until the hit.
- Push: on ihit & imemREN & !redirect:
  - write {PC+4, imemload} at wr_ptr;
  - wr_ptr++ (wraps modulo DEPTH);
  - PC <= PC+4.
  - Fill latency is one cycle: the entry is visible at the head the cycle after ihit when the queue was empty.
- Pop: on deq & out_valid & !redirect, rd_ptr++ (wraps).
  - deq while !out_valid is ignored and does not change state.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Full: count==DEPTH drives imemREN=0. A push cannot occur while full. A pop while full re-enables imemREN the next cycle (registered count, no combinational deq->imemREN path).
- Empty: out_valid=0; out_instr and out_npc are forced to 0, so decode sees a nop.
- Redirect (highest priority):
  - PC <= redirect_pc; wr_ptr=rd_ptr=0; count=0; halted cleared.
  - A same-cycle ihit is discarded, and so is a same-cycle deq.
  - out_valid=0 the next cycle; the first request to redirect_pc is issued the next cycle.
- Head outputs: out_valid, out_instr and out_npc are read combinationally from the entry at rd_ptr (show-ahead).
- PC arithmetic: modulo 2^WORD_W; PC+4 wraps at the top of the address space.
- Reset mid-operation: asserting nRST at any time immediately returns all state to the reset values, queue contents included.
- Storage: entries are not cleared on flush; validity is derived only from count.

Optional Feature:
- Macro: FETCH_HALT_EN.
- When defined:
  - a pushed instruction with opcode field [31:26]==6'b111111 (halt) sets a halted flag;
  - halted forces imemREN=0 and freezes PC at the halt address+4;
  - entries already queued, including the halt, drain normally;
  - only redirect or reset clears halted.
- When undefined: no halted state; fetch continues sequentially past halt and the datapath discards the extra fetches via redirect/flush.

Test Plan:
- Reset then ihit=1 continuously, deq=0, imemload=0x20010001 → imemaddr steps 0, 4, 8, 12; count reaches 4; imemREN=0; PC=16 held.
- From full, deq=1 for one cycle → out_npc of popped head=4, count=3; imemREN=1 next cycle; next push at address 16.
- Push and pop every cycle from count=1 → count stays 1 and out_npc increments by 4 each cycle across the pointer wrap (entries 3→0).
- Queue holds 3 entries; redirect=1, redirect_pc=0x00000100 with ihit=1 and deq=1 same cycle → next cycle count=0, out_valid=0, out_instr=0, imemaddr=0x100; the discarded fetch never appears.
- ihit=0 for 5 cycles with imemREN=1 → imemaddr stable, count unchanged; then ihit=1 → exactly one push.
- FETCH_HALT_EN defined, imemload=0xFC000000 at addr 8 → imemREN=0 after the push, PC=12; the queue drains to the halt entry. Then redirect_pc=0 → fetch resumes at 0. With the macro undefined → fetch continues at 12.
